// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue
//   Registered ALU control decoder between ID and EX. Decodes ALUOp, funct3,
//   funct7 and opcode bit 5 into an ALU control word. The result sits in a
//   one-entry output stage with a valid/ready handshake on both sides.
//   Optional RV32M ops hold the stage for MUL_LAT/DIV_LAT cycles and
//   back-pressure decode while they are in flight.
//
//   Build option: define RV32M_EN to decode R-type funct7==0000001 as
//   multiply/divide. When it is undefined those encodings are illegal and the
//   multicycle state and latency counter are not built.
//
// Ports
//   i_clk, i_rst           clock (rising edge), async active-high reset
//   i_valid / o_ready      decode-side handshake
//   i_ALUOp, i_funct3,
//   i_funct7, i_opecodeb5  instruction fields to decode
//   o_valid / i_ready      EX-side handshake
//   o_ALUCtrl              control word (bits above [4:0] are always 0)
//   o_illegal              entry is an illegal encoding
//   o_multicycle           entry is an M-extension op
//
// States
//   S_IDLE | stage empty, ready to accept
//   S_HOLD | entry valid, waiting for EX to consume it
//   S_MC   | M op in flight, counter running (RV32M_EN builds only)

module alu_ctrl_issue #(
    parameter int CTRL_W  = 5,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_ALUOp,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic              i_opecodeb5,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ALUCtrl,
    output logic              o_illegal,
    output logic              o_multicycle
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SRA  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SLL  = 5'b00111;
    localparam logic [4:0] OP_SLT  = 5'b01101;
    localparam logic [4:0] OP_SLTU = 5'b01110;
    localparam logic [4:0] OP_ILL  = 5'b11111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    logic [4:0] dec_ctrl;
    logic       dec_illegal;
    logic       dec_mc;

    always_comb begin
        dec_ctrl    = OP_ADD;
        dec_illegal = 1'b0;
        dec_mc      = 1'b0;
        case (i_ALUOp)
            2'b00: dec_ctrl = OP_ADD;
            2'b01: dec_ctrl = OP_SUB;
            2'b11: dec_illegal = 1'b1;
            default: begin
                if (i_opecodeb5 && (i_funct7 == F7_MEXT)) begin
`ifdef RV32M_EN
                    // M ops encode as 10 followed by funct3
                    dec_ctrl = {2'b10, i_funct3};
                    dec_mc   = 1'b1;
`else
                    dec_illegal = 1'b1;
`endif
                end else if (i_opecodeb5 && (i_funct7 != F7_BASE) && (i_funct7 != F7_ALT)) begin
                    dec_illegal = 1'b1;
                end else if (i_opecodeb5 && (i_funct7 == F7_ALT) &&
                             (i_funct3 != 3'b000) && (i_funct3 != 3'b101)) begin
                    dec_illegal = 1'b1;
                end else begin
                    case (i_funct3)
                        3'b000:  dec_ctrl = (i_opecodeb5 && (i_funct7 == F7_ALT)) ? OP_SUB : OP_ADD;
                        3'b001:  dec_ctrl = OP_SLL;
                        3'b010:  dec_ctrl = OP_SLT;
                        3'b011:  dec_ctrl = OP_SLTU;
                        3'b100:  dec_ctrl = OP_XOR;
                        // I-type shifts keep funct7[5] as the arithmetic select
                        3'b101:  dec_ctrl = i_funct7[5] ? OP_SRA : OP_SRL;
                        3'b110:  dec_ctrl = OP_OR;
                        default: dec_ctrl = OP_AND;
                    endcase
                end
            end
        endcase
        if (dec_illegal) begin
            dec_ctrl = OP_ILL;
        end
    end

`ifdef RV32M_EN
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_MC} state_t;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_ld;
`else
    typedef enum logic [1:0] {S_IDLE, S_HOLD} state_t;

    logic unused_lat;
    assign unused_lat = (MUL_LAT + DIV_LAT) != 0;
`endif

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              illegal_q, illegal_d;
    logic              mc_q, mc_d;
    logic              accept;

    assign o_valid      = (state_q == S_HOLD);
    assign o_ready      = (state_q == S_IDLE) || ((state_q == S_HOLD) && i_ready);
    assign accept       = i_valid && o_ready;
    assign o_ALUCtrl    = ctrl_q;
    assign o_illegal    = illegal_q;
    assign o_multicycle = mc_q;

`ifdef RV32M_EN
    // funct3[2] separates the divide group from the multiply group
    assign lat_ld = i_funct3[2] ? DIV_LD : MUL_LD;
`endif

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        mc_d      = mc_q;
`ifdef RV32M_EN
        cnt_d     = cnt_q;
`endif
        if (accept) begin
            ctrl_d    = CTRL_W'(dec_ctrl);
            illegal_d = dec_illegal;
            mc_d      = dec_mc;
            state_d   = S_HOLD;
`ifdef RV32M_EN
            // a latency of 1 skips the counter and lands straight in HOLD
            if (dec_mc && (lat_ld != '0)) begin
                state_d = S_MC;
                cnt_d   = lat_ld;
            end
`endif
        end else begin
            case (state_q)
                S_HOLD: if (i_ready) state_d = S_IDLE;
`ifdef RV32M_EN
                S_MC: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 1) state_d = S_HOLD;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            mc_q      <= 1'b0;
`ifdef RV32M_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            mc_q      <= mc_d;
`ifdef RV32M_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
module tb_alu_ctrl_issue;

    localparam int CTRL_W  = 5;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    localparam logic [4:0] C_ADD = 5'b00000, C_SUB = 5'b00001, C_OR = 5'b00010,
                           C_AND = 5'b00011, C_XOR = 5'b00100, C_SRA = 5'b00101,
                           C_SRL = 5'b00110, C_SLL = 5'b00111, C_SLT = 5'b01101,
                           C_SLTU = 5'b01110, C_ILL = 5'b11111;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid;
    logic              o_ready;
    logic [1:0]        i_ALUOp;
    logic [2:0]        i_funct3;
    logic [6:0]        i_funct7;
    logic              i_opecodeb5;
    logic              o_valid;
    logic              i_ready;
    logic [CTRL_W-1:0] o_ALUCtrl;
    logic              o_illegal;
    logic              o_multicycle;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] base_tbl [8];

    always #5 clk = ~clk;

    alu_ctrl_issue #(.CTRL_W(CTRL_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_ALUOp(i_ALUOp), .i_funct3(i_funct3), .i_funct7(i_funct7),
        .i_opecodeb5(i_opecodeb5), .o_valid(o_valid), .i_ready(i_ready),
        .o_ALUCtrl(o_ALUCtrl), .o_illegal(o_illegal), .o_multicycle(o_multicycle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic b5, input logic rdy);
        i_valid = v; i_ALUOp = op; i_funct3 = f3; i_funct7 = f7;
        i_opecodeb5 = b5; i_ready = rdy;
    endtask

    // Reference decode from the instruction-level rules: control word, flags
    // and the number of cycles until the entry becomes visible.
    task automatic ref_decode(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic b5, output logic [4:0] c, output logic ill,
                              output logic mc, output int lat);
        c = C_ADD; ill = 1'b0; mc = 1'b0; lat = 1;
        if (op == 2'd0) c = C_ADD;
        else if (op == 2'd1) c = C_SUB;
        else if (op == 2'd3) ill = 1'b1;
        else if (b5 && f7 == 7'h01) begin
`ifdef RV32M_EN
            mc = 1'b1;
            c = 5'd16 + 5'(f3);
            lat = (f3 >= 3'd4) ? DIV_LAT : MUL_LAT;
`else
            ill = 1'b1;
`endif
        end else if (b5 && !(f7 == 7'h00 || f7 == 7'h20)) ill = 1'b1;
        else if (b5 && f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5)) ill = 1'b1;
        else begin
            c = base_tbl[f3];
            if (f3 == 3'd0 && b5 && f7 == 7'h20) c = C_SUB;
            if (f3 == 3'd5 && f7[5]) c = C_SRA;
        end
        if (ill) c = C_ILL;
    endtask

    task automatic test_reset();
        int late;
        set_in(0, 2'b10, 3'b101, 7'h20, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        n_cmp++; if (o_valid !== 1'b0 || o_ALUCtrl !== '0 || o_illegal !== 1'b0 || o_multicycle !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs: got v=%b c=%b i=%b m=%b want 0/00000/0/0", o_valid, o_ALUCtrl, o_illegal, o_multicycle); end
        tick(); tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        // accept a shift and reset while it is held
        set_in(1, 2'b10, 3'b101, 7'h20, 1'b1, 1'b0);
        tick();
        i_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (o_valid !== 1'b0 || o_ALUCtrl !== '0) begin
            n_err++; $display("FAIL reset_in_hold: got v=%b c=%b want 0/00000", o_valid, o_ALUCtrl); end
        tick();
        rst = 1'b0;
`ifdef RV32M_EN
        #1;
        set_in(1, 2'b10, 3'b100, 7'h01, 1'b1, 1'b1);
        tick();
        i_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (o_valid !== 1'b0 || o_ALUCtrl !== '0 || o_multicycle !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_mc: got v=%b c=%b m=%b want 0/00000/0", o_valid, o_ALUCtrl, o_multicycle); end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid_mc_ready: got %b want 1", o_ready); end
        late = 0;
        for (int k = 0; k < 12; k++) begin
            if (o_valid !== 1'b0) late++;
            tick();
        end
        n_cmp++; if (late !== 0) begin n_err++; $display("FAIL reset_no_late_valid: got %0d valid cycles want 0", late); end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        set_in(1, 2'b10, 3'b000, 7'h20, 1'b1, 1'b1);
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b want 1", o_ready); end
        tick();
        set_in(1, 2'b10, 3'b000, 7'h20, 1'b0, 1'b1);
        #1;
        n_cmp++; if (o_valid !== 1'b1 || o_ALUCtrl !== C_SUB || o_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_sub: got v=%b c=%b r=%b want 1/00001/1", o_valid, o_ALUCtrl, o_ready); end
        tick();
        i_valid = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b1 || o_ALUCtrl !== C_ADD || o_illegal !== 1'b0) begin
            n_err++; $display("FAIL b2b_add: got v=%b c=%b i=%b want 1/00000/0", o_valid, o_ALUCtrl, o_illegal); end
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", o_valid); end
    endtask

    task automatic test_stall();
        set_in(1, 2'b10, 3'b101, 7'h20, 1'b1, 1'b1);
        tick();
        i_valid = 1'b0; i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (o_valid !== 1'b1 || o_ALUCtrl !== C_SRA || o_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_hold%0d: got v=%b c=%b r=%b want 1/00101/0", k, o_valid, o_ALUCtrl, o_ready); end
            tick();
        end
        i_ready = 1'b1;
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b want 1", o_ready); end
        tick();
        n_cmp++; if (o_valid !== 1'b0 || o_ALUCtrl !== C_SRA) begin
            n_err++; $display("FAIL stall_done: got v=%b c=%b want 0/00101", o_valid, o_ALUCtrl); end
    endtask

    task automatic test_illegal();
        set_in(1, 2'b11, 3'b000, 7'h00, 1'b0, 1'b1);
        tick();
        set_in(1, 2'b10, 3'b000, 7'h02, 1'b1, 1'b1);
        #1;
        n_cmp++; if (o_valid !== 1'b1 || o_ALUCtrl !== C_ILL || o_illegal !== 1'b1) begin
            n_err++; $display("FAIL illegal_aluop11: got v=%b c=%b i=%b want 1/11111/1", o_valid, o_ALUCtrl, o_illegal); end
        tick();
        i_valid = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b1 || o_ALUCtrl !== C_ILL || o_illegal !== 1'b1) begin
            n_err++; $display("FAIL illegal_f7: got v=%b c=%b i=%b want 1/11111/1", o_valid, o_ALUCtrl, o_illegal); end
        tick();
    endtask

    task automatic test_mext();
`ifdef RV32M_EN
        int busy;
        set_in(1, 2'b10, 3'b100, 7'h01, 1'b1, 1'b0);
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL div_accept_ready: got %b want 1", o_ready); end
        tick();
        i_valid = 1'b0;
        busy = 0;
        for (int k = 1; k < DIV_LAT; k++) begin
            if (o_ready !== 1'b0 || o_valid !== 1'b0) busy++;
            tick();
        end
        n_cmp++; if (busy !== 0) begin n_err++; $display("FAIL div_busy: got %0d bad cycles want 0", busy); end
        n_cmp++; if (o_valid !== 1'b1 || o_ALUCtrl !== 5'b10100 || o_multicycle !== 1'b1 || o_ready !== 1'b0) begin
            n_err++; $display("FAIL div_result: got v=%b c=%b m=%b r=%b want 1/10100/1/0", o_valid, o_ALUCtrl, o_multicycle, o_ready); end
        i_ready = 1'b1;
        tick();
`else
        set_in(1, 2'b10, 3'b000, 7'h01, 1'b1, 1'b1);
        tick();
        i_valid = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b1 || o_ALUCtrl !== C_ILL || o_illegal !== 1'b1 || o_multicycle !== 1'b0) begin
            n_err++; $display("FAIL mul_off: got v=%b c=%b i=%b m=%b want 1/11111/1/0", o_valid, o_ALUCtrl, o_illegal, o_multicycle); end
        tick();
`endif
    endtask

    task automatic test_random();
        logic       m_valid, m_ill, m_mc, exp_ready;
        logic [4:0] m_ctrl, c;
        logic       ill, mc;
        int         m_wait, lat, bad;
        logic [6:0] f7;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_valid = 0; m_ill = 0; m_mc = 0; m_ctrl = '0; m_wait = 0; bad = 0;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            set_in(($urandom_range(0, 9) < 7), ($urandom_range(0, 5) < 4) ? 2'b10 : 2'($urandom),
                   3'($urandom), f7, 1'($urandom), ($urandom_range(0, 9) < 6));
            #1;
            exp_ready = (!m_valid && m_wait == 0) || (m_valid && i_ready);
            n_cmp++;
            if (o_valid !== m_valid || o_ready !== exp_ready || o_ALUCtrl !== m_ctrl ||
                o_illegal !== m_ill || o_multicycle !== m_mc) begin
                n_err++;
                if (bad < 10) $display("FAIL random_%0d: got v=%b r=%b c=%b i=%b m=%b want v=%b r=%b c=%b i=%b m=%b",
                    n, o_valid, o_ready, o_ALUCtrl, o_illegal, o_multicycle, m_valid, exp_ready, m_ctrl, m_ill, m_mc);
                bad++;
            end
            if (m_valid && i_ready) m_valid = 1'b0;
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_valid = 1'b1;
            end
            if (i_valid && exp_ready) begin
                ref_decode(i_ALUOp, i_funct3, i_funct7, i_opecodeb5, c, ill, mc, lat);
                m_ctrl = c; m_ill = ill; m_mc = mc;
                m_valid = (lat == 1);
                m_wait = lat - 1;
            end
            tick();
        end
    endtask

    initial begin
        base_tbl = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};
        rst = 1'b1;
        set_in(0, 2'b00, 3'b000, 7'h00, 1'b0, 1'b0);
        #2;
        test_reset();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_mext();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
